// File: rtl/delta_accumulator.sv
// Move-delta accumulator.
// Command beats pass through a one-entry stage register and are folded into a
// saturating signed accumulator. The final beat of a move publishes the delta.
// A consumed delta can be committed into a clamped, unsigned running total.
module delta_accumulator #(
  parameter int unsigned DELTA_W = 21,
  parameter int unsigned TOTAL_W = 23
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [4:0]         cmd,
  input  logic               cmd_last,
  input  logic [17:0]        dist_data,
  output logic               delta_valid,
  input  logic               delta_ready,
  output logic [DELTA_W-1:0] delta,
  input  logic               commit,
  input  logic               total_load,
  input  logic [TOTAL_W-1:0] total_in,
  output logic [TOTAL_W-1:0] total,
  output logic               sel_err
);

  localparam int unsigned DIST_W = 18;
  localparam int unsigned SUM_W  = DELTA_W + 1;
  localparam int unsigned TSUM_W = TOTAL_W + 2;

  typedef enum logic [1:0] {
    OP_ZERO = 2'b00,
    OP_PLS  = 2'b01,
    OP_MNS  = 2'b10,
    OP_DNOP = 2'b11
  } op_e;

  localparam logic [DELTA_W-1:0] ACC_MAX = {1'b0, {(DELTA_W-1){1'b1}}};
  localparam logic [DELTA_W-1:0] ACC_MIN = {1'b1, {(DELTA_W-1){1'b0}}};

  logic               stage_valid_q, stage_valid_d;
  logic               stage_last_q,  stage_last_d;
  op_e                stage_op_q,    stage_op_d;
  logic [2:0]         stage_sel_q,   stage_sel_d;
  logic [DIST_W-1:0]  stage_data_q,  stage_data_d;
  logic [DELTA_W-1:0] acc_q,         acc_d;
  logic [DELTA_W-1:0] delta_q,       delta_d;
  logic               delta_valid_q, delta_valid_d;
  logic [TOTAL_W-1:0] total_q,       total_d;
  logic               sel_err_q,     sel_err_d;

  logic               ready_int;
  logic               accept;
  logic               consume;
  logic [SUM_W-1:0]   sum;
  logic [DELTA_W-1:0] op_res;
  logic [TSUM_W-1:0]  tsum;
  logic [TOTAL_W-1:0] total_clamped;

  // A staged last beat or a pending delta blocks new beats; reset forces the port low.
  assign ready_int = !(delta_valid_q | (stage_valid_q & stage_last_q));
  assign cmd_ready = reset_n & ready_int;

  // Next-state logic: stage capture, saturating accumulate, delta hand-off, total update.
  always_comb begin
    stage_valid_d = 1'b0;
    stage_last_d  = stage_last_q;
    stage_op_d    = stage_op_q;
    stage_sel_d   = stage_sel_q;
    stage_data_d  = stage_data_q;
    acc_d         = acc_q;
    delta_d       = delta_q;
    delta_valid_d = delta_valid_q;
    total_d       = total_q;
    sel_err_d     = sel_err_q;

    accept  = cmd_valid & ready_int;
    consume = delta_valid_q & delta_ready;

    if (accept) begin
      stage_valid_d = 1'b1;
      stage_last_d  = cmd_last;
      stage_op_d    = op_e'(cmd[1:0]);
      stage_sel_d   = cmd[4:2];
      stage_data_d  = dist_data;
    end

    case (stage_op_q)
      OP_ZERO: sum = '0;
      OP_PLS:  sum = {acc_q[DELTA_W-1], acc_q} + SUM_W'(stage_data_q);
      OP_MNS:  sum = {acc_q[DELTA_W-1], acc_q} - SUM_W'(stage_data_q);
      default: sum = {acc_q[DELTA_W-1], acc_q};
    endcase

    // Top two bits disagreeing means the DELTA_W range was exceeded.
    if (sum[SUM_W-1] != sum[SUM_W-2]) begin
      op_res = sum[SUM_W-1] ? ACC_MIN : ACC_MAX;
    end else begin
      op_res = sum[DELTA_W-1:0];
    end

    if (consume) begin
      delta_valid_d = 1'b0;
    end

    if (stage_valid_q) begin
      if ((stage_sel_q == 3'b011) || (stage_sel_q == 3'b111)) begin
        sel_err_d = 1'b1;
      end
      if (stage_last_q) begin
        delta_d       = op_res;
        delta_valid_d = 1'b1;
        acc_d         = '0;
      end else begin
        acc_d = op_res;
      end
    end

    tsum = {2'b00, total_q} + {{(TSUM_W-DELTA_W){delta_q[DELTA_W-1]}}, delta_q};
    if (tsum[TSUM_W-1]) begin
      total_clamped = '0;
    end else if (tsum[TOTAL_W]) begin
      total_clamped = '1;
    end else begin
      total_clamped = tsum[TOTAL_W-1:0];
    end

    if (total_load) begin
      total_d = total_in;
    end else if (commit && consume) begin
      total_d = total_clamped;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_valid_q <= 1'b0;
      stage_last_q  <= 1'b0;
      stage_op_q    <= OP_ZERO;
      stage_sel_q   <= '0;
      stage_data_q  <= '0;
      acc_q         <= '0;
      delta_q       <= '0;
      delta_valid_q <= 1'b0;
      total_q       <= '0;
      sel_err_q     <= 1'b0;
    end else begin
      stage_valid_q <= stage_valid_d;
      stage_last_q  <= stage_last_d;
      stage_op_q    <= stage_op_d;
      stage_sel_q   <= stage_sel_d;
      stage_data_q  <= stage_data_d;
      acc_q         <= acc_d;
      delta_q       <= delta_d;
      delta_valid_q <= delta_valid_d;
      total_q       <= total_d;
      sel_err_q     <= sel_err_d;
    end
  end

  assign delta_valid = delta_valid_q;
  assign delta       = delta_q;
  assign total       = total_q;
  assign sel_err     = sel_err_q;

endmodule

// File: tb/tb_delta_accumulator.sv
// Directed bench for delta_accumulator: a beat table plus hand-written sequences.
module tb_delta_accumulator;

  localparam logic [1:0] OP_ZERO = 2'b00;
  localparam logic [1:0] OP_PLS  = 2'b01;
  localparam logic [1:0] OP_MNS  = 2'b10;
  localparam logic [1:0] OP_DNOP = 2'b11;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd;
  logic        cmd_last;
  logic [17:0] dist_data;
  logic        delta_valid;
  logic        delta_ready;
  logic [20:0] delta;
  logic        commit;
  logic        total_load;
  logic [22:0] total_in;
  logic [22:0] total;
  logic        sel_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  sel;
    logic [1:0]  op;
    logic        last;
    logic [17:0] data;
    logic [20:0] exp_delta;
    logic        exp_err;
    int          hold;
  } vec_t;

  vec_t vecs[$];

  delta_accumulator #(.DELTA_W(21), .TOTAL_W(23)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd(cmd), .cmd_last(cmd_last), .dist_data(dist_data),
    .delta_valid(delta_valid), .delta_ready(delta_ready), .delta(delta),
    .commit(commit), .total_load(total_load), .total_in(total_in),
    .total(total), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] sel, input logic [1:0] op, input logic last,
                     input logic [17:0] data, input logic [20:0] exp_delta,
                     input logic exp_err, input int hold);
    vec_t v;
    v.sel = sel; v.op = op; v.last = last; v.data = data;
    v.exp_delta = exp_delta; v.exp_err = exp_err; v.hold = hold;
    vecs.push_back(v);
  endtask

  // Present a beat and return just after the edge that accepts it.
  task automatic send_beat(input logic [2:0] sel, input logic [1:0] op,
                           input logic last, input logic [17:0] data);
    int n = 0;
    cmd_valid = 1'b1; cmd = {sel, op}; cmd_last = last; dist_data = data;
    while (!cmd_ready && n < 20) begin
      step();
      n++;
    end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL cmd_ready_timeout: got 0 expected 1");
    end
    step();
    cmd_valid = 1'b0; cmd_last = 1'b0;
  endtask

  task automatic wait_dv();
    int n = 0;
    while (!delta_valid && n < 10) begin
      step();
      n++;
    end
    if (!delta_valid) begin
      checks++; errors++;
      $display("FAIL delta_valid_timeout: got 0 expected 1");
    end
  endtask

  task automatic consume(input logic do_commit);
    commit = do_commit; delta_ready = 1'b1;
    step();
    commit = 1'b0; delta_ready = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd = '0; cmd_last = 1'b0; dist_data = '0;
    delta_ready = 1'b0; commit = 1'b0; total_load = 1'b0; total_in = '0;

    // Move: ZERO, +0x10000, +0x8000, -0x4000 -> 0x14000, held 5 cycles
    add(3'd0, OP_ZERO, 1'b0, 18'h00000, 21'h0, 1'b0, 0);
    add(3'd0, OP_PLS,  1'b0, 18'h10000, 21'h0, 1'b0, 0);
    add(3'd0, OP_PLS,  1'b0, 18'h08000, 21'h0, 1'b0, 0);
    add(3'd0, OP_MNS,  1'b1, 18'h04000, 21'h014000, 1'b0, 5);
    // Negative saturation
    add(3'd0, OP_ZERO, 1'b0, 18'h00000, 21'h0, 1'b0, 0);
    for (int i = 0; i < 4; i++) add(3'd0, OP_MNS, 1'b0, 18'h3FFFF, 21'h0, 1'b0, 0);
    add(3'd0, OP_MNS,  1'b1, 18'h3FFFF, 21'h100000, 1'b0, 0);
    // Positive saturation (4 x 0x3FFFF = 0xFFFFC, fifth clamps)
    for (int i = 0; i < 4; i++) add(3'd1, OP_PLS, 1'b0, 18'h3FFFF, 21'h0, 1'b0, 0);
    add(3'd2, OP_PLS,  1'b1, 18'h3FFFF, 21'h0FFFFF, 1'b0, 0);
    // DNOP as final beat keeps the sum
    add(3'd0, OP_PLS,  1'b0, 18'h00123, 21'h0, 1'b0, 0);
    add(3'd0, OP_DNOP, 1'b1, 18'h3FFFF, 21'h000123, 1'b0, 0);
    // ZERO mid-move discards earlier beats
    add(3'd0, OP_PLS,  1'b0, 18'h00500, 21'h0, 1'b0, 0);
    add(3'd0, OP_ZERO, 1'b0, 18'h00500, 21'h0, 1'b0, 0);
    add(3'd0, OP_MNS,  1'b1, 18'h00010, 21'h1FFFF0, 1'b0, 1);
    // Legal select 101, then illegal 011
    add(3'd5, OP_PLS,  1'b1, 18'h00007, 21'h000007, 1'b0, 0);
    add(3'd3, OP_PLS,  1'b1, 18'h00100, 21'h000100, 1'b1, 0);

    // Reset state
    #3;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_delta_valid", 32'(delta_valid), 32'd0);
    chk("rst_delta", 32'(delta), 32'd0);
    chk("rst_total", 32'(total), 32'd0);
    chk("rst_sel_err", 32'(sel_err), 32'd0);
    step(); step();
    reset_n = 1'b1;
    #1;
    chk("ready_after_rst", 32'(cmd_ready), 32'd1);

    // Table-driven moves
    foreach (vecs[i]) begin
      send_beat(vecs[i].sel, vecs[i].op, vecs[i].last, vecs[i].data);
      if (vecs[i].last) begin
        chk("dv_low_at_E0", 32'(delta_valid), 32'd0);
        chk("ready_low_staged_last", 32'(cmd_ready), 32'd0);
        step();
        chk("dv_at_E1", 32'(delta_valid), 32'd1);
        chk("delta_value", 32'(delta), 32'(vecs[i].exp_delta));
        chk("sel_err", 32'(sel_err), 32'(vecs[i].exp_err));
        for (int h = 0; h < vecs[i].hold; h++) begin
          step();
          chk("hold_delta", 32'(delta), 32'(vecs[i].exp_delta));
          chk("hold_dv", 32'(delta_valid), 32'd1);
          chk("hold_ready_low", 32'(cmd_ready), 32'd0);
        end
        consume(1'b0);
        chk("dv_drop", 32'(delta_valid), 32'd0);
        chk("ready_back", 32'(cmd_ready), 32'd1);
      end
    end
    chk("total_no_commit", 32'(total), 32'd0);

    // Total load and commit
    total_load = 1'b1; total_in = 23'h200000;
    step();
    total_load = 1'b0;
    chk("total_load", 32'(total), 32'h200000);
    send_beat(3'd0, OP_MNS, 1'b1, 18'h14000);
    wait_dv();
    chk("neg_delta", 32'(delta), 32'h1EC000);
    consume(1'b1);
    chk("total_commit", 32'(total), 32'h1EC000);
    chk("commit_dv_drop", 32'(delta_valid), 32'd0);

    send_beat(3'd0, OP_PLS, 1'b1, 18'h00100);
    wait_dv();
    commit = 1'b1;
    step(); step();
    commit = 1'b0;
    chk("commit_no_ready", 32'(total), 32'h1EC000);
    consume(1'b0);
    chk("consume_no_commit", 32'(total), 32'h1EC000);

    total_load = 1'b1; total_in = 23'h7FFF00;
    step();
    total_load = 1'b0;
    send_beat(3'd0, OP_PLS, 1'b1, 18'h00200);
    wait_dv();
    consume(1'b1);
    chk("total_clamp_hi", 32'(total), 32'h7FFFFF);

    total_load = 1'b1; total_in = 23'h000010;
    step();
    total_load = 1'b0;
    send_beat(3'd0, OP_MNS, 1'b1, 18'h00100);
    wait_dv();
    consume(1'b1);
    chk("total_clamp_lo", 32'(total), 32'd0);

    send_beat(3'd0, OP_PLS, 1'b1, 18'h00300);
    wait_dv();
    total_load = 1'b1; total_in = 23'h000055;
    consume(1'b1);
    total_load = 1'b0;
    chk("load_priority", 32'(total), 32'h55);
    chk("load_prio_consumed", 32'(delta_valid), 32'd0);

    // Reset mid-move discards the partial sum
    send_beat(3'd0, OP_PLS, 1'b0, 18'h00040);
    send_beat(3'd0, OP_PLS, 1'b0, 18'h00040);
    reset_n = 1'b0;
    #2;
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("mid_rst_dv", 32'(delta_valid), 32'd0);
    chk("mid_rst_delta", 32'(delta), 32'd0);
    chk("mid_rst_total", 32'(total), 32'd0);
    chk("mid_rst_sel_err", 32'(sel_err), 32'd0);
    step();
    reset_n = 1'b1;
    #1;
    chk("mid_rst_ready_after", 32'(cmd_ready), 32'd1);
    step(); step();
    chk("no_partial_delta", 32'(delta_valid), 32'd0);
    send_beat(3'd0, OP_ZERO, 1'b0, 18'h00000);
    send_beat(3'd0, OP_PLS, 1'b1, 18'h00020);
    wait_dv();
    chk("post_rst_delta", 32'(delta), 32'h20);
    consume(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
